// File: rtl/my_ram8_pkg.sv
// my_ram8_pkg: word and address sizes shared by the RAM hierarchy and the CPU.
package my_ram8_pkg;
    localparam int HACK_WORD_W = 16;
    localparam int RAM8_ADDR_W = 3;
    localparam int RAM8_DEPTH  = 1 << RAM8_ADDR_W;
endpackage

// File: rtl/my_ram8_dmux8way.sv
// my_ram8_dmux8way: 1-to-2 demux and the 1-to-8 tree that steers a load strobe.
import my_ram8_pkg::*;

module my_dmux (
    input  logic in,
    input  logic sel,
    output logic a,
    output logic b
);
    assign a = in & ~sel;
    assign b = in & sel;
endmodule

module my_dmux8way (
    input  logic       in,
    input  logic [2:0] sel,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       h
);
    logic w_abcd, w_efgh, w_ab, w_cd, w_ef, w_gh;
    // MSB splits first so the leaves come out in address order
    my_dmux u_l1   (.in(in),     .sel(sel[2]), .a(w_abcd), .b(w_efgh));
    my_dmux u_l2_0 (.in(w_abcd), .sel(sel[1]), .a(w_ab),   .b(w_cd));
    my_dmux u_l2_1 (.in(w_efgh), .sel(sel[1]), .a(w_ef),   .b(w_gh));
    my_dmux u_l3_0 (.in(w_ab),   .sel(sel[0]), .a(a),      .b(b));
    my_dmux u_l3_1 (.in(w_cd),   .sel(sel[0]), .a(c),      .b(d));
    my_dmux u_l3_2 (.in(w_ef),   .sel(sel[0]), .a(e),      .b(f));
    my_dmux u_l3_3 (.in(w_gh),   .sel(sel[0]), .a(g),      .b(h));
endmodule

// File: rtl/my_ram8.sv
// my_ram8: eight-word register file, demuxed load, combinational read mux.
import my_ram8_pkg::*;

module my_ram8 #(
    parameter int WIDTH = HACK_WORD_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in,
    input  logic                   load,
    input  logic [RAM8_ADDR_W-1:0] address,
    output logic [WIDTH-1:0]       out
);
    logic [RAM8_DEPTH-1:0] w_ld;
    logic [WIDTH-1:0]      r_mem [RAM8_DEPTH];

    my_dmux8way u_dmux (
        .in(load), .sel(address),
        .a(w_ld[0]), .b(w_ld[1]), .c(w_ld[2]), .d(w_ld[3]),
        .e(w_ld[4]), .f(w_ld[5]), .g(w_ld[6]), .h(w_ld[7])
    );

    always_ff @(posedge clk) begin
        for (int i = 0; i < RAM8_DEPTH; i++)
            if (reset)
                r_mem[i] <= '0;
            else if (w_ld[i])
                r_mem[i] <= in;
    end

    // no write-through: a same-cycle write shows only after the edge
    assign out = r_mem[address];
endmodule

// File: tb/tb_my_ram8.sv
// tb_my_ram8: directed steps with hand-computed expectations for my_ram8.
module tb_my_ram8;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] in = '0;
    logic        load = 1'b0;
    logic [2:0]  address = '0;
    logic [15:0] out;
    logic [15:0] m [8];
    int checks = 0;
    int errors = 0;

    my_ram8 dut (.clk(clk), .reset(reset), .in(in), .load(load), .address(address), .out(out));

    always #20 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] exp);
        checks++;
        $display("t=%0t reset=%b load=%b address=%0d in=%h out=(%h, %h)", $time, reset, load, address, in, out, exp);
        assert (out === exp) else begin
            errors++;
            $error("FAIL %s: out=%h expected=%h", tag, out, exp);
        end
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            check(tag, m[a]);
        end
    endtask

    initial begin
        for (int a = 0; a < 8; a++) m[a] = 16'h0000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sweep("reset");

        for (int n = 0; n < 8; n++) begin
            address = 3'(n);
            in = 16'(16'h1111 * n);
            load = 1'b1;
            tick();
            m[n] = in;
            check("walk_write", in);
            load = 1'b0;
            sweep("walk_others");
        end
        sweep("walk_final");

        address = 3'd3; in = 16'hBEEF; load = 1'b1;
        tick();
        m[3] = 16'hBEEF;
        in = 16'hCAFE;
        #1;
        check("same_cycle_before", 16'hBEEF);
        tick();
        m[3] = 16'hCAFE;
        check("same_cycle_after", 16'hCAFE);
        load = 1'b0;
        address = 3'd2; #1; check("same_cycle_a2", 16'h2222);
        address = 3'd4; #1; check("same_cycle_a4", 16'h4444);

        address = 3'd5; in = 16'hFFFF; load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("load_low", 16'h5555);
        end

        reset = 1'b1; load = 1'b1; address = 3'd6; in = 16'h1234;
        tick();
        for (int a = 0; a < 8; a++) m[a] = 16'h0000;
        sweep("reset_priority");
        address = 3'd6;
        reset = 1'b0;
        tick();
        m[6] = 16'h1234;
        check("reset_release_write", 16'h1234);
        load = 1'b0;
        sweep("reset_release_all");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
